// File: rtl/div_seq_32_pkg.sv
// Shared constants and state encoding for the
// 32-bit sequential restoring divider.
package div_seq_32_pkg;

  localparam int DW   = 32;
  localparam int ITER = 32;
  localparam int CW   = $clog2(ITER);

  typedef enum logic [2:0] {
    IDLE,
    PRE_N,
    PRE_D,
    RUN,
    POST_Q,
    POST_R,
    DONE
  } state_t;

endpackage

// File: rtl/div_seq_32_adc32.sv
// Single shared adder: 32-bit add with carry-in
// on both the low bit and an extended bit 32.
module adc32
  import div_seq_32_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          c0,
  output logic [DW:0]   sum
);

  assign sum = {1'b0, a}
             + {c0, b}
             + {{DW{1'b0}}, c0};

endmodule

// File: rtl/div_seq_32.sv
// Sequential signed/unsigned 32-bit divider,
// fixed latency, one shared adder per cycle.
module div_seq_32
  import div_seq_32_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          sign,
  input  logic [DW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [DW-1:0] remainder,
  output logic          div_zero
);

  state_t        state;
  logic [DW-1:0] wq;
  logic [DW-1:0] wr;
  logic [DW-1:0] wd;
  logic [DW-1:0] org;
  logic          sgn;
  logic          dneg;
  logic          dz;
  logic [CW-1:0] cnt;

  logic [DW-1:0] add_a;
  logic [DW-1:0] add_b;
  logic [DW:0]   sum;
  logic [DW-1:0] trial;
  logic          take;

  assign trial = {wr[DW-2:0], wq[DW-1]};
  // sum[32] set means trial < divisor
  assign take  = wr[DW-1] | ~sum[DW];

  always_comb begin
    add_a = '0;
    add_b = ~wq;
    case (state)
      PRE_D:  add_b = ~wd;
      RUN: begin
        add_a = trial;
        add_b = ~wd;
      end
      POST_R: add_b = ~wr;
      default: add_b = ~wq;
    endcase
  end

  adc32 u_adc (
    .a   (add_a),
    .b   (add_b),
    .c0  (1'b1),
    .sum (sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      wq        <= '0;
      wr        <= '0;
      wd        <= '0;
      org       <= '0;
      sgn       <= 1'b0;
      dneg      <= 1'b0;
      dz        <= 1'b0;
      cnt       <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            sgn   <= sign;
            wq    <= dividend;
            org   <= dividend;
            wd    <= divisor;
            wr    <= '0;
            dneg  <= divisor[DW-1];
            dz    <= (divisor == '0);
            busy  <= 1'b1;
            state <= PRE_N;
          end
        end
        PRE_N: begin
          if (sgn && wq[DW-1])
            wq <= sum[DW-1:0];
          state <= PRE_D;
        end
        PRE_D: begin
          if (sgn && wd[DW-1])
            wd <= sum[DW-1:0];
          cnt   <= CW'(ITER - 1);
          state <= RUN;
        end
        RUN: begin
          wr <= take ? sum[DW-1:0] : trial;
          wq <= {wq[DW-2:0], take};
          if (cnt == '0)
            state <= POST_Q;
          else
            cnt <= cnt - 1'b1;
        end
        POST_Q: begin
          if (sgn && (org[DW-1] ^ dneg))
            wq <= sum[DW-1:0];
          state <= POST_R;
        end
        POST_R: begin
          done     <= 1'b1;
          div_zero <= dz;
          quotient <= dz ? '1 : wq;
          if (dz)
            remainder <= org;
          else if (sgn && org[DW-1])
            remainder <= sum[DW-1:0];
          else
            remainder <= wr;
          state <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
